// File: rtl/issue_rat_redeemq_pkg.sv
// Shared issue-stage definitions for the PRF reclaim queue.
package issue_rat_redeemq_pkg;

   localparam int unsigned PRF_W         = 6;
   localparam int unsigned REDEEMQ_DEPTH = 8;
   localparam int unsigned REDEEMQ_PTR_W = $clog2(REDEEMQ_DEPTH);

   typedef logic [PRF_W-1:0] prf_idx_t;

   // PRF 0 is hardwired to x0 and is never returned to the free list
   localparam prf_idx_t PRF_ZERO = PRF_W'(0);

endpackage

// File: rtl/issue_rat_redeemq_if.sv
// Retire-to-free-list reclaim bus: 2-wide retire release in, 1-wide redeem out.
interface issue_rat_redeemq_if
   import issue_rat_redeemq_pkg::*;
#(
   parameter int unsigned PTR_W = REDEEMQ_PTR_W
) ();

   prf_idx_t       i_retire_prf0;
   logic           i_retire_valid0;
   prf_idx_t       i_retire_prf1;
   logic           i_retire_valid1;
   logic           o_retire_ready;

   prf_idx_t       o_redeemed_prf;
   logic           o_redeemed_valid;
   logic           i_redeemed_ready;

   logic [PTR_W:0] o_count;

   // Retire/free-list side driving the queue
   modport master (
      output i_retire_prf0, i_retire_valid0, i_retire_prf1, i_retire_valid1,
      output i_redeemed_ready,
      input  o_retire_ready, o_redeemed_prf, o_redeemed_valid, o_count
   );

   // The reclaim queue itself
   modport slave (
      input  i_retire_prf0, i_retire_valid0, i_retire_prf1, i_retire_valid1,
      input  i_redeemed_ready,
      output o_retire_ready, o_redeemed_prf, o_redeemed_valid, o_count
   );

endinterface

// File: rtl/issue_rat_redeemq.sv
// Reclaim queue: absorbs up to two stale PRF indices per cycle from retire,
// drops PRF 0, and hands them to the free list one per cycle in FIFO order.
module issue_rat_redeemq
   import issue_rat_redeemq_pkg::*;
#(
   parameter int unsigned DEPTH = REDEEMQ_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   issue_rat_redeemq_if.slave  bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // Storage carries no reset; only the pointers define what is live
   prf_idx_t          mem_q [DEPTH];

   logic [CNT_W-1:0]  wptr_q, wptr_d;
   logic [CNT_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_c;
   logic              ready_c;
   logic              valid_c;
   logic              acc0_c, acc1_c;
   logic              deq_c;
   logic [PTR_W-1:0]  widx0_c, widx1_c;
   logic [PTR_W-1:0]  ridx_c;

   // Occupancy, ready and accept/dequeue decisions from registered state only
   always_comb begin
      count_c = wptr_q - rptr_q;
      ready_c = (count_c <= CNT_W'(DEPTH - 2));
      valid_c = (count_c != '0);
      acc0_c  = bus.i_retire_valid0 & ready_c & (bus.i_retire_prf0 != PRF_ZERO);
      acc1_c  = bus.i_retire_valid1 & ready_c & (bus.i_retire_prf1 != PRF_ZERO);
      deq_c   = valid_c & bus.i_redeemed_ready;
      ridx_c  = rptr_q[PTR_W-1:0];
   end

   // Two-wide write mux: slot 1 lands behind slot 0 only when slot 0 was taken
   always_comb begin
      widx0_c = wptr_q[PTR_W-1:0];
      widx1_c = widx0_c;
      if (acc0_c) begin
         widx1_c = widx0_c + PTR_W'(1);
      end
   end

   // Pointer next-state; index slices wrap naturally across the array end
   always_comb begin
      wptr_d = wptr_q + CNT_W'(acc0_c) + CNT_W'(acc1_c);
      rptr_d = rptr_q + CNT_W'(deq_c);
   end

   // Pointer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Entry storage; the two write indices never collide when both slots accept
   always_ff @(posedge clk) begin
      if (acc0_c) begin
         mem_q[widx0_c] <= bus.i_retire_prf0;
      end
      if (acc1_c) begin
         mem_q[widx1_c] <= bus.i_retire_prf1;
      end
   end

   // Show-ahead head and status straight from the registers
   always_comb begin
      bus.o_count          = count_c;
      bus.o_retire_ready   = ready_c;
      bus.o_redeemed_valid = valid_c;
      bus.o_redeemed_prf   = valid_c ? mem_q[ridx_c] : PRF_ZERO;
   end

endmodule

// File: tb/tb_issue_rat_redeemq.sv
// Bench for the PRF reclaim queue: directed cases plus randomized traffic
// checked every cycle against a queue-based model.
module tb_issue_rat_redeemq;
   import issue_rat_redeemq_pkg::*;

   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   issue_rat_redeemq_if bus ();

   issue_rat_redeemq #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Model state: the queue contents in FIFO order
   int q[$];
   int deq_total = 0;
   int acc_total = 0;
   bit straddled = 1'b0;
   bit chk_en    = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit mdl_ready();
      return (DEPTH - q.size()) >= 2;
   endfunction

   // Model update on the clock edge from pre-edge queue state
   always @(posedge clk or negedge reset) begin
      bit rdy;
      if (!reset) begin
         q.delete();
         acc_total = 0;
      end else begin
         rdy = mdl_ready();
         if (q.size() != 0 && bus.i_redeemed_ready) begin
            void'(q.pop_front());
            deq_total++;
         end
         if (rdy && bus.i_retire_valid0 && bus.i_retire_prf0 != 0) begin
            if (bus.i_retire_valid1 && bus.i_retire_prf1 != 0 && (acc_total % DEPTH) == DEPTH - 1)
               straddled = 1'b1;
            q.push_back(int'(bus.i_retire_prf0));
            acc_total++;
         end
         if (rdy && bus.i_retire_valid1 && bus.i_retire_prf1 != 0) begin
            q.push_back(int'(bus.i_retire_prf1));
            acc_total++;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en && reset) begin
         chk("valid", int'(bus.o_redeemed_valid), int'(q.size() != 0));
         chk("head",  int'(bus.o_redeemed_prf),  (q.size() != 0) ? q[0] : 0);
         chk("count", int'(bus.o_count),         q.size());
         chk("ready", int'(bus.o_retire_ready),  int'(mdl_ready()));
      end
   end

   task automatic drive(input int p0, input int v0, input int p1, input int v1, input int rr);
      bus.i_retire_prf0    = PRF_W'(p0);
      bus.i_retire_valid0  = 1'(v0);
      bus.i_retire_prf1    = PRF_W'(p1);
      bus.i_retire_valid1  = 1'(v1);
      bus.i_redeemed_ready = 1'(rr);
   endtask

   function automatic int rand_prf();
      if ($urandom_range(0, 7) == 0) return 0;
      return int'($urandom_range(1, 63));
   endfunction

   task automatic drain_all(input string name);
      int n;
      n = 0;
      drive(0, 0, 0, 0, 1);
      while (bus.o_count != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, int'(bus.o_count), 0);
   endtask

   initial begin
      int target;
      int n;

      drive(0, 0, 0, 0, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset  = 1'b1;
      chk_en = 1'b1;

      // Reset then idle
      @(negedge clk);
      chk("rst_valid", int'(bus.o_redeemed_valid), 0);
      chk("rst_ready", int'(bus.o_retire_ready), 1);
      chk("rst_count", int'(bus.o_count), 0);
      chk("rst_prf",   int'(bus.o_redeemed_prf), 0);

      // Pair 5,9 with the free list always ready
      drive(5, 1, 9, 1, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 1);
      chk("pair_head0", int'(bus.o_redeemed_prf), 5);
      chk("pair_cnt0",  int'(bus.o_count), 2);
      @(negedge clk);
      chk("pair_head1", int'(bus.o_redeemed_prf), 9);
      chk("pair_cnt1",  int'(bus.o_count), 1);
      @(negedge clk);
      chk("pair_cnt2",  int'(bus.o_count), 0);
      chk("pair_empty", int'(bus.o_redeemed_valid), 0);

      // PRF 0 filtered; slot 1 alone is legal
      drive(0, 1, 12, 1, 0);
      @(negedge clk);
      chk("zero_cnt",  int'(bus.o_count), 1);
      chk("zero_head", int'(bus.o_redeemed_prf), 12);
      drive(0, 0, 7, 1, 0);
      @(negedge clk);
      chk("s1_cnt",  int'(bus.o_count), 2);
      chk("s1_head", int'(bus.o_redeemed_prf), 12);
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("s1_head2", int'(bus.o_redeemed_prf), 7);
      @(negedge clk);
      chk("s1_done", int'(bus.o_count), 0);

      // Fill to full with no drain
      for (int i = 0; i < 4; i++) begin
         drive(10 + 2 * i, 1, 11 + 2 * i, 1, 0);
         @(negedge clk);
      end
      chk("full_cnt",   int'(bus.o_count), 8);
      chk("full_ready", int'(bus.o_retire_ready), 0);
      drive(20, 1, 21, 1, 0);
      @(negedge clk);
      chk("full_drop_cnt",  int'(bus.o_count), 8);
      chk("full_drop_head", int'(bus.o_redeemed_prf), 10);
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("c7_cnt",   int'(bus.o_count), 7);
      chk("c7_ready", int'(bus.o_retire_ready), 0);
      chk("c7_head",  int'(bus.o_redeemed_prf), 11);
      @(negedge clk);
      chk("c6_cnt",   int'(bus.o_count), 6);
      chk("c6_ready", int'(bus.o_retire_ready), 1);
      chk("c6_head",  int'(bus.o_redeemed_prf), 12);
      drain_all("full_drain");

      // One single entry so the following pairs land on odd indices
      drive(0, 0, 33, 1, 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("odd_done", int'(bus.o_count), 0);

      // Steady state: pairs in, one out, until full
      n = 0;
      while (q.size() < DEPTH && n < 50) begin
         if (mdl_ready())
            drive($urandom_range(1, 63), 1, $urandom_range(1, 63), 1, (q.size() < DEPTH - 2) ? 1 : 0);
         else
            drive(0, 0, 0, 0, 0);
         @(negedge clk);
         n++;
      end
      chk("steady_full", q.size(), DEPTH);
      chk("steady_dut_full", int'(bus.o_count), DEPTH);

      // Drain 64 entries with random back-pressure while refilling
      target = deq_total + 64;
      n = 0;
      while (deq_total < target && n < 2000) begin
         if (mdl_ready() && $urandom_range(0, 3) != 0)
            drive(rand_prf(), int'($urandom_range(0, 3) != 0), rand_prf(),
                  int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)));
         else
            drive(0, 0, 0, 0, int'($urandom_range(0, 1)));
         @(negedge clk);
         n++;
      end
      chk("drain64_done", int'(deq_total >= target), 1);
      chk("straddle_seen", int'(straddled), 1);

      // Asynchronous reset mid-stream with the queue occupied
      drive(41, 1, 42, 1, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0);
      chk("pre_rst_nonempty", int'(bus.o_count != 0), 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", int'(bus.o_redeemed_valid), 0);
      chk("arst_ready", int'(bus.o_retire_ready), 1);
      chk("arst_count", int'(bus.o_count), 0);
      chk("arst_prf",   int'(bus.o_redeemed_prf), 0);
      @(negedge clk);
      #2 reset = 1'b1;

      // Traffic after reset release
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (mdl_ready())
            drive(rand_prf(), 1, rand_prf(), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
         else
            drive(0, 0, 0, 0, int'($urandom_range(0, 1)));
      end
      @(negedge clk);
      drain_all("final_drain");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/issue_rat_redeemq.md
Name: issue_rat_redeemq

Overview:
- Retire-side reclaim queue that sits directly upstream of the 64-entry RAT PRF free list.
- Accepts up to 2 released (stale) PRF indices per clock from commit/retire.
- Filters out PRF 0, which is hardwired to x0 and never freed.
- Buffers the indices and feeds the free list redemption port 1 per clock through a valid/ready handshake, absorbing the 2-in/1-out rate mismatch.

Parameters:
- DEPTH, 8, queue entries; power of 2, minimum 4.
- PTR_W, 3, log2(DEPTH); derived, not overridden.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  reset; one clock; reset is asynchronous and active-low.
- i_retire_prf0  in  6  first released PRF index (older instruction).
- i_retire_valid0  in  1  i_retire_prf0 valid.
- i_retire_prf1  in  6  second released PRF index (younger instruction).
- i_retire_valid1  in  1  i_retire_prf1 valid.
- o_retire_ready  out  1  queue can accept 2 entries this cycle.
- o_redeemed_prf  out  6  head PRF index to the free list.
- o_redeemed_valid  out  1  head entry valid.
- i_redeemed_ready  in  1  free list accepts head this cycle.
- o_count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 6-bit array.
- Pointers: wptr and rptr, each PTR_W+1 bits with a wrap bit. Entry index = pointer[PTR_W-1:0].
- count = wptr - rptr (modulo 2^(PTR_W+1)). o_count is this value, taken straight from the registers.
- Reset (asserted low, asynchronous):
  - wptr = rptr = 0.
  - o_count = 0, o_redeemed_valid = 0, o_redeemed_prf = 0, o_retire_ready = 1.
  - Array contents are don't-care.
- Reset released mid-operation: all queued entries are lost. The free list is reset alongside, so no leak arises.
- Accept condition, per slot: acc0 = i_retire_valid0 & o_retire_ready & (i_retire_prf0 != 0). acc1 is the same for slot 1.
- o_retire_ready:
  - = (DEPTH - count) >= 2, computed from registered count only.
  - It does not depend on i_redeemed_ready (no combinational ready path).
  - With exactly 1 free slot, ready = 0, even if only one valid is asserted.
- Valids while o_retire_ready = 0 are ignored (dropped). Retire must hold them; the bench treats this as an upstream protocol violation.
- Write ordering (enqueue):
  - acc0 & acc1: prf0 written at wptr, prf1 at wptr+1, wptr += 2.
  - Exactly one accepted: that index written at wptr, wptr += 1. Slot 1 alone is legal.
  - PRF 0 on either slot: silently discarded, consumes no entry.
- Read side (show-ahead):
  - o_redeemed_valid = (count != 0).
  - o_redeemed_prf = mem[rptr] when valid, else 0.
  - Dequeue when o_redeemed_valid & i_redeemed_ready: rptr += 1.
- Latency: an entry accepted in cycle N is visible at the head in cycle N+1 at the earliest. There is no bypass from input to output.
- Simultaneous enqueue and dequeue: next count = count + nin - nout, with nin in {0,1,2} and nout in {0,1}. The head read uses pre-update state.
- Full (count = DEPTH): o_retire_ready = 0. Dequeue continues normally.
- Empty: o_redeemed_valid = 0, and i_redeemed_ready is ignored.
- Wrap-around:
  - Pointers wrap modulo 2^(PTR_W+1).
  - A 2-entry write may straddle the array end: entry DEPTH-1 then entry 0.
- Order guarantee: FIFO order, with prf0 ahead of prf1 within a cycle.
- No duplicate detection; the free list is responsible for index integrity.

Decomposition:
- Shared issue package holds:
  - PRF_W = 6.
  - PRF_ZERO = 6'd0.
  - REDEEMQ_DEPTH default = 8.
- No sub-module. Storage, pointers and the 2-wide write mux are flat; a generic FIFO cannot do a 2-write/1-read port mix.

Test Plan:
- Reset then idle → o_redeemed_valid=0, o_retire_ready=1, o_count=0, o_redeemed_prf=0.
- Cycle 1 {prf0=5,v0=1,prf1=9,v1=1}, i_redeemed_ready=1 → cycle 2 head=5 and dequeued; cycle 3 head=9 and dequeued; cycle 4 o_count=0.
- {prf0=0,v0=1,prf1=12,v1=1} → only 12 enqueued; o_count=1. Then {v0=0,prf1=7,v1=1} → 7 enqueued after 12.
- Fill with i_redeemed_ready=0, 4 cycles of 2 entries (10..17) → o_count=8, o_retire_ready=0. Valid inputs during full are not accepted. Ready returns only when count<=6.
- At count=7 → o_retire_ready=0. One dequeue → count=6, ready=1 the following cycle.
- Wrap test:
  - Steady state: pairs in and 1 out per cycle until full.
  - Then drain 64 entries with randomized i_redeemed_ready.
  - Required: output order equals input order, including a pair straddling entry 7→0, and no loss or duplication.
  - Assert reset low mid-stream → outputs return to reset values immediately (asynchronously).
